add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 14 +
 rtl/adder.sv | 24 ++
 rtl/add_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: FSM encoding and
// default sizing.
package add_arbiter_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : add_arbiter_pkg

// File: rtl/adder.sv
// Plain ripple-carry adder. The result wraps modulo 2^WIDTH and there is no
// carry-out port, so callers rebuild the carry from the operand and sum MSBs.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    // Bit-serial carry chain, LSB first.
    always_comb begin
        logic c;
        // NOTE: every variable written in always_comb gets a value before any
        // branch or loop reads it; otherwise synthesis infers a latch.
        c   = 1'b0;
        out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out[i] = in1[i] ^ in2[i] ^ c;
            c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
        end
    end

endmodule : adder

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters. A transaction
// takes three cycles: grant and latch operands (IDLE->LOAD), register the sum
// (LOAD->DONE), and pulse done before releasing the grant (DONE->IDLE).
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic [WIDTH-1:0]      sum,
    output logic                  carry,
    output logic                  busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [NREQ-1:0]    r_gnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic               w_found_hi;
    logic               w_found_any;
    logic [PTR_W-1:0]   w_win_hi;
    logic [PTR_W-1:0]   w_win_lo;
    logic [PTR_W-1:0]   w_winner;
    logic [NREQ-1:0]    w_gnt_new;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH-1:0]   w_adder_out;
    logic               w_carry;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;

    // Round-robin pick: lowest requester at or above ptr, else lowest overall
    // (the wrap from NREQ-1 back to 0).
    always_comb begin
        w_found_hi  = 1'b0;
        w_found_any = 1'b0;
        w_win_hi    = '0;
        w_win_lo    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (PTR_W'(i) >= r_ptr) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_win_hi   = PTR_W'(i);
            end
            if (req[i] && !w_found_any) begin
                w_found_any = 1'b1;
                w_win_lo    = PTR_W'(i);
            end
        end
        w_winner  = w_found_hi ? w_win_hi : w_win_lo;
        w_gnt_new = NREQ'(1) << w_winner;
    end

    // Operand mux selecting the winner's slices.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == w_winner) begin
                w_sel_a = op_a[i*WIDTH +: WIDTH];
                w_sel_b = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Index of the current owner, used to advance the pointer past it.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
        w_ptr_nxt = (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end

    // The shared adder only ever sees the latched operands.
    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .in1 (r_op_a),
        .in2 (r_op_b),
        .out (w_adder_out)
    );

    assign w_carry = (r_op_a[WIDTH-1] & r_op_b[WIDTH-1])
                   | ((r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1]) & ~w_adder_out[WIDTH-1]);

    // Next-state logic for the three-phase transaction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found_any) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers, each updated only in the phase that owns it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_gnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found_any) begin
                        r_op_a <= w_sel_a;
                        r_op_b <= w_sel_b;
                        r_gnt  <= w_gnt_new;
                    end
                end
                ST_LOAD: begin
                    r_sum   <= w_adder_out;
                    r_carry <= w_carry;
                end
                ST_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sum   = r_sum;
    assign carry = r_carry;
    assign done  = (r_state == ST_DONE);
    assign busy  = (r_state != ST_IDLE);

endmodule : add_arbiter
